// File: rtl/mem_copy_engine_pkg.sv
// rtl/mem_copy_engine_pkg.sv - shared state encoding and constants for the copy/fill engine
package mem_copy_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  // A byte address is usable only if it sits on a word boundary
  function automatic logic is_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// rtl/mem_copy_engine.sv - word-granular memory copy / constant fill engine
module mem_copy_engine
  import mem_copy_engine_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      fill_val,
  input  logic             abort,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  output logic             mem_we,
  input  logic [31:0]      mem_rd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [LEN_W-1:0] words_done
);

  state_e           state_q, state_d;
  logic [31:0]      src_ptr_q, src_ptr_d;
  logic [31:0]      dst_ptr_q, dst_ptr_d;
  logic [31:0]      buf_q, buf_d;
  logic [31:0]      fill_q, fill_d;
  logic             mode_q, mode_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] words_done_q, words_done_d;
  logic             err_q, err_d;
  logic [31:0]      mem_a_q, mem_a_d;
  logic [31:0]      mem_wd_q, mem_wd_d;
  logic             mem_we_q, mem_we_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Next-state and datapath updates; outputs are then derived from the next state so they register cleanly
  always_comb begin
    state_d      = state_q;
    src_ptr_d    = src_ptr_q;
    dst_ptr_d    = dst_ptr_q;
    buf_d        = buf_q;
    fill_d       = fill_q;
    mode_d       = mode_q;
    rem_d        = rem_q;
    words_done_d = words_done_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_ptr_d    = src;
          dst_ptr_d    = dst;
          rem_d        = len;
          mode_d       = mode;
          fill_d       = fill_val;
          words_done_d = '0;
          err_d        = 1'b0;
          if (!is_aligned(dst) || (mode == MODE_COPY && !is_aligned(src))) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end else if (len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = (mode == MODE_COPY) ? ST_READ : ST_WRITE;
          end
        end
      end
      ST_READ: begin
        buf_d = mem_rd;
        if (abort) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        words_done_d = words_done_q + LEN_W'(1);
        src_ptr_d    = src_ptr_q + WORD_BYTES;
        dst_ptr_d    = dst_ptr_q + WORD_BYTES;
        rem_d        = rem_q - LEN_W'(1);
        if (abort) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (rem_q == LEN_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = (mode_q == MODE_COPY) ? ST_READ : ST_WRITE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    mem_a_d  = '0;
    mem_wd_d = '0;
    mem_we_d = 1'b0;
    busy_d   = (state_d == ST_READ) || (state_d == ST_WRITE);
    done_d   = (state_d == ST_DONE);
    if (state_d == ST_READ) begin
      mem_a_d = src_ptr_d;
    end else if (state_d == ST_WRITE) begin
      mem_a_d  = dst_ptr_d;
      mem_we_d = 1'b1;
      mem_wd_d = (mode_d == MODE_FILL) ? fill_d : buf_d;
    end
  end

  // All state and registered outputs, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      src_ptr_q    <= '0;
      dst_ptr_q    <= '0;
      buf_q        <= '0;
      fill_q       <= '0;
      mode_q       <= MODE_COPY;
      rem_q        <= '0;
      words_done_q <= '0;
      err_q        <= 1'b0;
      mem_a_q      <= '0;
      mem_wd_q     <= '0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_ptr_q    <= src_ptr_d;
      dst_ptr_q    <= dst_ptr_d;
      buf_q        <= buf_d;
      fill_q       <= fill_d;
      mode_q       <= mode_d;
      rem_q        <= rem_d;
      words_done_q <= words_done_d;
      err_q        <= err_d;
      mem_a_q      <= mem_a_d;
      mem_wd_q     <= mem_wd_d;
      mem_we_q     <= mem_we_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_wd     = mem_wd_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign words_done = words_done_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// tb/tb_mem_copy_engine.sv - scoreboard bench for mem_copy_engine
module tb_mem_copy_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] src = '0;
  logic [31:0] dst = '0;
  logic [15:0] len = '0;
  logic [31:0] fill_val = '0;
  logic        abort = 1'b0;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_done;

  mem_copy_engine #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .abort(abort), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd), .busy(busy),
    .done(done), .err(err), .words_done(words_done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:255];
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] a; logic [31:0] d; int c; } wr_t;
  typedef struct { logic e; logic [15:0] wd; int c; } dn_t;
  wr_t wq[$];
  dn_t dq[$];

  int n_vec = 0;
  int n_bad = 0;
  int we_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected writes / done pulses whenever the DUT presents them
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      if (wq.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", mem_a, w.a);
        chk("wr_data", mem_wd, w.d);
        chk("wr_cycle", cyc, w.c);
      end
    end
    if (done) begin
      if (dq.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        dn_t x;
        x = dq.pop_front();
        chk("done_err", {31'd0, err}, {31'd0, x.e});
        chk("done_words", {16'd0, words_done}, {16'd0, x.wd});
        chk("done_cycle", cyc, x.c);
      end
    end
  end

  task automatic launch(input logic m, input logic [31:0] s, input logic [31:0] d,
                        input logic [15:0] l, input logic [31:0] fv, output int e0);
    @(negedge clk);
    mode = m; src = s; dst = d; len = l; fill_val = fv; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e0 = cyc;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input int c);
    wr_t w;
    w.a = a; w.d = d; w.c = c;
    wq.push_back(w);
  endtask

  task automatic push_dn(input logic e, input logic [15:0] wd, input int c);
    dn_t x;
    x.e = e; x.wd = wd; x.c = c;
    dq.push_back(x);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((dq.size() != 0 || wq.size() != 0) && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({nm, "_drain_done"}, dq.size(), 0);
    chk({nm, "_drain_wr"}, wq.size(), 0);
    @(negedge clk);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_mem_a"}, mem_a, 0);
    chk({nm, "_mem_wd"}, mem_wd, 0);
    chk({nm, "_mem_we"}, {31'd0, mem_we}, 0);
    chk({nm, "_busy"}, {31'd0, busy}, 0);
    chk({nm, "_done"}, {31'd0, done}, 0);
    chk({nm, "_err"}, {31'd0, err}, 0);
    chk({nm, "_words"}, {16'd0, words_done}, 0);
  endtask

  initial begin
    int e0;
    int w0;
    for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
    mem[0] <= 32'd11; mem[1] <= 32'd22; mem[2] <= 32'd33; mem[3] <= 32'd44;
    mem[4] <= 32'd55; mem[5] <= 32'd66; mem[6] <= 32'd77; mem[7] <= 32'd88;
    mem[128] <= 32'hA5A5_0001; mem[129] <= 32'hA5A5_0002;
    mem[130] <= 32'hA5A5_0003; mem[131] <= 32'hA5A5_0004;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
    @(negedge clk);

    // Copy four words 0..3 to 0x40
    launch(1'b0, 32'h0, 32'h40, 16'd4, 32'h0, e0);
    push_wr(32'h40, 32'd11, e0 + 1);
    push_wr(32'h44, 32'd22, e0 + 3);
    push_wr(32'h48, 32'd33, e0 + 5);
    push_wr(32'h4C, 32'd44, e0 + 7);
    push_dn(1'b0, 16'd4, e0 + 8);
    drain("copy");
    chk("copy_mem16", mem[16], 32'd11);
    chk("copy_mem19", mem[19], 32'd44);
    chk("copy_err_held", {31'd0, err}, 0);

    // Fill three words at 0x100
    w0 = we_cnt;
    launch(1'b1, 32'h3, 32'h100, 16'd3, 32'hDEADBEEF, e0);
    push_wr(32'h100, 32'hDEADBEEF, e0);
    push_wr(32'h104, 32'hDEADBEEF, e0 + 1);
    push_wr(32'h108, 32'hDEADBEEF, e0 + 2);
    push_dn(1'b0, 16'd3, e0 + 3);
    drain("fill");
    chk("fill_we_cycles", we_cnt - w0, 3);
    chk("fill_mem66", mem[66], 32'hDEADBEEF);
    chk("fill_mem67", mem[67], 32'd0);

    // Misaligned destination is rejected
    w0 = we_cnt;
    launch(1'b0, 32'h0, 32'h42, 16'd4, 32'h0, e0);
    push_dn(1'b1, 16'd0, e0);
    drain("misalign");
    chk("misalign_no_we", we_cnt - w0, 0);
    chk("misalign_err_held", {31'd0, err}, 1);

    // Zero length completes without access and clears err
    w0 = we_cnt;
    launch(1'b0, 32'h0, 32'h80, 16'd0, 32'h0, e0);
    push_dn(1'b0, 16'd0, e0);
    drain("len0");
    chk("len0_no_we", we_cnt - w0, 0);

    // Abort during word 3 write of an 8-word copy
    launch(1'b0, 32'h0, 32'h80, 16'd8, 32'h0, e0);
    push_wr(32'h80, 32'd11, e0 + 1);
    push_wr(32'h84, 32'd22, e0 + 3);
    push_wr(32'h88, 32'd33, e0 + 5);
    push_dn(1'b1, 16'd3, e0 + 6);
    while (cyc < e0 + 5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    drain("abort");
    chk("abort_mem35", mem[35], 32'd0);
    chk("abort_err_held", {31'd0, err}, 1);

    // Overlapping copy propagates the first word forward
    launch(1'b0, 32'h0, 32'h4, 16'd3, 32'h0, e0);
    push_wr(32'h4, 32'd11, e0 + 1);
    push_wr(32'h8, 32'd11, e0 + 3);
    push_wr(32'hC, 32'd11, e0 + 5);
    push_dn(1'b0, 16'd3, e0 + 6);
    drain("overlap");
    chk("overlap_mem3", mem[3], 32'd11);

    // Reset during the second read abandons the transfer
    w0 = we_cnt;
    launch(1'b0, 32'h200, 32'h300, 16'd4, 32'h0, e0);
    push_wr(32'h300, 32'hA5A5_0001, e0 + 1);
    while (cyc < e0 + 2) @(negedge clk);
    chk("rst_in_read_busy", {31'd0, busy}, 1);
    rst = 1'b0;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("midrst_we_count", we_cnt - w0, 1);
    chk("midrst_mem193", mem[193], 32'd0);
    chk("midrst_wq_empty", wq.size(), 0);
    chk("midrst_idle_busy", {31'd0, busy}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
